// File: rtl/kernl_memory.sv
// rtl/kernl_memory.sv - kernel weight store: 4-word write beats via internal pointer, single-word registered reads
module kernl_memory #(
   parameter int DATA_WIDTH    = 128,
   parameter int DATA_WIDTH2   = 32,
   parameter int ADDRESS_WIDTH = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_WIDTH-1:0]    Data_In,
   input  logic                     Last_Address,
   input  logic [ADDRESS_WIDTH-1:0] Address,
   input  logic                     Write_En,
   input  logic                     En,
   output logic [DATA_WIDTH2-1:0]   Data_out
);

   localparam int DEPTH          = 2 ** ADDRESS_WIDTH;
   localparam int WORDS_PER_BEAT = DATA_WIDTH / DATA_WIDTH2;

   logic [DATA_WIDTH2-1:0]   mem_q [DEPTH];
   logic [DATA_WIDTH2-1:0]   mem_d [DEPTH];
   logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [DATA_WIDTH2-1:0]   data_out_q, data_out_d;

   // Next-state: full beats append at the pointer (wrapping), the final short beat
   // stores one word and rewinds the pointer so the next kernel load starts at word 0.
   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      data_out_d = data_out_q;
      if (En) begin
         if (Write_En) begin
            if (Last_Address) begin
               for (int k = 0; k < WORDS_PER_BEAT; k++) begin
                  mem_d[wr_ptr_q + ADDRESS_WIDTH'(k)] = Data_In[k*DATA_WIDTH2 +: DATA_WIDTH2];
               end
               wr_ptr_d = wr_ptr_q + ADDRESS_WIDTH'(WORDS_PER_BEAT);
            end else begin
               mem_d[wr_ptr_q] = Data_In[DATA_WIDTH2-1:0];
               wr_ptr_d        = '0;
            end
         end else begin
            data_out_d = mem_q[Address];
         end
      end
   end

   // State registers; reset wipes the whole array so unwritten words read back as zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q   <= '0;
         data_out_q <= '0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         data_out_q <= data_out_d;
      end
   end

   assign Data_out = data_out_q;

endmodule

// File: tb/tb_kernl_memory.sv
// tb/tb_kernl_memory.sv - scoreboard bench for kernl_memory
module tb_kernl_memory;

   logic         clk;
   logic         rst;
   logic [127:0] Data_In;
   logic         Last_Address;
   logic [5:0]   Address;
   logic         Write_En;
   logic         En;
   logic [31:0]  Data_out;

   kernl_memory dut (
      .clk          (clk),
      .rst          (rst),
      .Data_In      (Data_In),
      .Last_Address (Last_Address),
      .Address      (Address),
      .Write_En     (Write_En),
      .En           (En),
      .Data_out     (Data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] model [64];
   int          mptr;
   logic [31:0] sb [$];
   int          n_checks;
   int          n_fail;

   function automatic logic [127:0] rand_beat();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 64; i++) model[i] = 32'h0;
      mptr = 0;
   endfunction

   task automatic write_beat(input logic [127:0] d, input logic la);
      @(negedge clk);
      En = 1'b1; Write_En = 1'b1; Last_Address = la; Data_In = d;
      @(posedge clk);
      #1;
      if (la) begin
         for (int k = 0; k < 4; k++) model[(mptr + k) % 64] = d[32*k +: 32];
         mptr = (mptr + 4) % 64;
      end else begin
         model[mptr] = d[31:0];
         mptr = 0;
      end
   endtask

   task automatic issue_read(input int addr);
      @(negedge clk);
      En = 1'b1; Write_En = 1'b0; Address = 6'(addr);
      sb.push_back(model[addr]);
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      @(negedge clk);
      En = 1'b0; Write_En = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] exp;
      rst = 1'b1; En = 1'b0; Write_En = 1'b0; Last_Address = 1'b0;
      Address = '0; Data_In = '0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (Data_out !== 32'h0) begin
         n_fail++; $display("FAIL reset_dout actual=%h required=%h", Data_out, 32'h0);
      end
      @(negedge clk);
      rst = 1'b0;
      foreach (model[i]) begin
         if (i == 0 || i == 5 || i == 63) begin
            issue_read(i);
            exp = sb.pop_front();
            n_checks++;
            if (Data_out !== exp) begin
               n_fail++; $display("FAIL reset_mem[%0d] actual=%h required=%h", i, Data_out, exp);
            end
         end
      end
      go_idle();
   endtask

   task automatic load3();
      write_beat(rand_beat(), 1'b1);
      write_beat(rand_beat(), 1'b1);
      write_beat(rand_beat(), 1'b0);
      go_idle();
   endtask

   task automatic test_load_read();
      logic [31:0] exp;
      load3();
      for (int a = 0; a <= 9; a++) begin
         issue_read(a);
         exp = sb.pop_front();
         n_checks++;
         if (Data_out !== exp) begin
            n_fail++; $display("FAIL load_read[%0d] actual=%h required=%h", a, Data_out, exp);
         end
      end
      go_idle();
   endtask

   task automatic test_repeat_reads();
      logic [31:0] exp;
      for (int p = 0; p < 9; p++) begin
         for (int a = 0; a <= 8; a++) begin
            issue_read(a);
            exp = sb.pop_front();
            n_checks++;
            if (Data_out !== exp) begin
               n_fail++; $display("FAIL repeat_read p%0d[%0d] actual=%h required=%h", p, a, Data_out, exp);
            end
         end
      end
      go_idle();
   endtask

   task automatic test_reload();
      logic [31:0] exp;
      logic [31:0] held;
      issue_read(7);
      held = sb.pop_front();
      load3();
      n_checks++;
      if (Data_out !== held) begin
         n_fail++; $display("FAIL hold_during_write actual=%h required=%h", Data_out, held);
      end
      for (int a = 0; a <= 11; a++) begin
         issue_read(a);
         exp = sb.pop_front();
         n_checks++;
         if (Data_out !== exp) begin
            n_fail++; $display("FAIL reload_read[%0d] actual=%h required=%h", a, Data_out, exp);
         end
      end
      go_idle();
   endtask

   task automatic test_en_hold();
      logic [31:0] exp;
      issue_read(5);
      exp = sb.pop_front();
      n_checks++;
      if (Data_out !== exp) begin
         n_fail++; $display("FAIL en_hold_read5 actual=%h required=%h", Data_out, exp);
      end
      @(negedge clk);
      En = 1'b0; Write_En = 1'b0; Address = 6'd0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (Data_out !== exp) begin
         n_fail++; $display("FAIL en_hold_dout actual=%h required=%h", Data_out, exp);
      end
      // Disabled write attempt must change neither memory nor pointer
      @(negedge clk);
      En = 1'b0; Write_En = 1'b1; Last_Address = 1'b1; Data_In = rand_beat();
      @(posedge clk);
      #1;
      write_beat(rand_beat(), 1'b1);
      go_idle();
      for (int a = 0; a <= 4; a++) begin
         issue_read(a);
         exp = sb.pop_front();
         n_checks++;
         if (Data_out !== exp) begin
            n_fail++; $display("FAIL en_off_nowrite[%0d] actual=%h required=%h", a, Data_out, exp);
         end
      end
      go_idle();
   endtask

   task automatic test_reset_midload();
      logic [31:0] exp;
      logic [127:0] g;
      write_beat(rand_beat(), 1'b1);
      write_beat(128'hA5A5_0000_1111_2222_3333_4444_DEAD_BEEF, 1'b1);
      issue_read(4);
      exp = sb.pop_front();
      n_checks++;
      if (Data_out !== exp) begin
         n_fail++; $display("FAIL midload_pre actual=%h required=%h", Data_out, exp);
      end
      // Assert reset between edges with a write still driven; output must clear at once
      @(negedge clk);
      En = 1'b1; Write_En = 1'b1; Last_Address = 1'b1; Data_In = rand_beat();
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (Data_out !== 32'h0) begin
         n_fail++; $display("FAIL async_reset_dout actual=%h required=%h", Data_out, 32'h0);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      En = 1'b0; Write_En = 1'b0;
      rst = 1'b0;
      model_clear();
      issue_read(0);
      exp = sb.pop_front();
      n_checks++;
      if (Data_out !== exp) begin
         n_fail++; $display("FAIL midload_addr0 actual=%h required=%h", Data_out, exp);
      end
      g = rand_beat();
      write_beat(g, 1'b1);
      for (int a = 0; a <= 4; a++) begin
         issue_read(a);
         exp = sb.pop_front();
         n_checks++;
         if (Data_out !== exp) begin
            n_fail++; $display("FAIL midload_G[%0d] actual=%h required=%h", a, Data_out, exp);
         end
      end
      go_idle();
   endtask

   task automatic test_wrap();
      logic [31:0] exp;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      for (int b = 0; b < 17; b++) write_beat(rand_beat(), 1'b1);
      go_idle();
      for (int a = 0; a < 64; a++) begin
         if (a < 8 || a >= 60) begin
            issue_read(a);
            exp = sb.pop_front();
            n_checks++;
            if (Data_out !== exp) begin
               n_fail++; $display("FAIL wrap_read[%0d] actual=%h required=%h", a, Data_out, exp);
            end
         end
      end
      // Pointer must now sit at 4: a short beat lands on word 4
      write_beat(rand_beat(), 1'b0);
      issue_read(4);
      exp = sb.pop_front();
      n_checks++;
      if (Data_out !== exp) begin
         n_fail++; $display("FAIL wrap_ptr4 actual=%h required=%h", Data_out, exp);
      end
      go_idle();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_load_read();
      test_repeat_reads();
      test_reload();
      test_en_hold();
      test_reset_midload();
      test_wrap();
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++; $display("FAIL scoreboard_leftover actual=%0d required=0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
